mem_axi_bridge: RTL and testbench

Memory-side responder for the data cache's strobe/ready port: it accepts one single-word read or write-through request at a time and converts it into a single-beat AXI4 transaction. It sits between the cache's memory interface (`m_*` on the cache) and the SoC AXI interconnect. It drives the ready pulse and read data back to the cache.

---
 rtl/mem_axi_bridge.sv | 180 ++++++++++++++++++
 tb/tb_mem_axi_bridge.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_axi_bridge.sv
// Cache-side strobe/ready responder that turns one single-word read or write-through
// request into a single-beat AXI4 transaction, one request in flight at a time.
module mem_axi_bridge #(
  parameter int A_WIDTH = 32,
  parameter int ID_W    = 4,
  parameter int TXN_ID  = 1
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic [A_WIDTH-1:0] s_a,
  input  logic [31:0]        s_din,
  output logic [31:0]        s_dout,
  input  logic               s_strobe,
  input  logic               s_rw,
  input  logic [3:0]         s_wen,
  input  logic [1:0]         s_size,
  output logic               s_ready,
  output logic [ID_W-1:0]    arid,
  output logic [A_WIDTH-1:0] araddr,
  output logic [7:0]         arlen,
  output logic [2:0]         arsize,
  output logic [1:0]         arburst,
  output logic               arvalid,
  input  logic               arready,
  input  logic [ID_W-1:0]    rid,
  input  logic [31:0]        rdata,
  input  logic [1:0]         rresp,
  input  logic               rlast,
  input  logic               rvalid,
  output logic               rready,
  output logic [ID_W-1:0]    awid,
  output logic [A_WIDTH-1:0] awaddr,
  output logic [7:0]         awlen,
  output logic [2:0]         awsize,
  output logic [1:0]         awburst,
  output logic               awvalid,
  input  logic               awready,
  output logic [ID_W-1:0]    wid,
  output logic [31:0]        wdata,
  output logic [3:0]         wstrb,
  output logic               wlast,
  output logic               wvalid,
  input  logic               wready,
  input  logic [ID_W-1:0]    bid,
  input  logic [1:0]         bresp,
  input  logic               bvalid,
  output logic               bready
);

  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WREQ, WRESP, DONE} state_t;

  state_t             state_q;
  logic [A_WIDTH-1:0] addr_q;
  logic [31:0]        din_q;
  logic [31:0]        dout_q;
  logic [3:0]         wen_q;
  logic [1:0]         size_q;
  logic               rw_q;
  logic               arvalid_q;
  logic               awvalid_q;
  logic               wvalid_q;
  logic               rready_q;
  logic               bready_q;
  logic               s_ready_q;
  logic               aw_done_q;
  logic               w_done_q;
  logic               aw_done_d;
  logic               w_done_d;

  // AW and W complete independently; either may land first or both together.
  assign aw_done_d = aw_done_q | (awvalid_q & awready);
  assign w_done_d  = w_done_q | (wvalid_q & wready);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      din_q     <= '0;
      dout_q    <= '0;
      wen_q     <= '0;
      size_q    <= '0;
      rw_q      <= 1'b0;
      arvalid_q <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      rready_q  <= 1'b0;
      bready_q  <= 1'b0;
      s_ready_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      s_ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (s_strobe) begin
            addr_q    <= s_a;
            din_q     <= s_din;
            wen_q     <= s_wen;
            size_q    <= s_size;
            rw_q      <= s_rw;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            if (s_rw) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= WREQ;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= RADDR;
            end
          end
        end
        RADDR: begin
          if (arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RDATA;
          end
        end
        RDATA: begin
          if (rvalid) begin
            dout_q    <= rdata;
            rready_q  <= 1'b0;
            s_ready_q <= 1'b1;
            state_q   <= DONE;
          end
        end
        WREQ: begin
          aw_done_q <= aw_done_d;
          w_done_q  <= w_done_d;
          awvalid_q <= ~aw_done_d;
          wvalid_q  <= ~w_done_d;
          if (aw_done_d && w_done_d) begin
            bready_q <= 1'b1;
            state_q  <= WRESP;
          end
        end
        WRESP: begin
          if (bvalid) begin
            bready_q  <= 1'b0;
            s_ready_q <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_dout  = dout_q;
  assign s_ready = s_ready_q;

  assign arid    = ID_W'(TXN_ID);
  assign araddr  = addr_q;
  assign arlen   = 8'd0;
  assign arsize  = {1'b0, size_q};
  assign arburst = 2'b01;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;

  assign awid    = ID_W'(TXN_ID);
  assign awaddr  = addr_q;
  assign awlen   = 8'd0;
  assign awsize  = {1'b0, size_q};
  assign awburst = 2'b01;
  assign awvalid = awvalid_q;

  assign wid     = ID_W'(TXN_ID);
  assign wdata   = din_q;
  assign wstrb   = wen_q;
  assign wlast   = 1'b1;
  assign wvalid  = wvalid_q;
  assign bready  = bready_q;

  // Responses always complete the request and only one ID is ever outstanding.
  logic unused_resp;
  assign unused_resp = ^{rid, rresp, rlast, bid, bresp, rw_q};

endmodule

// File: tb/tb_mem_axi_bridge.sv
// Bench for mem_axi_bridge: directed and random requests against a word-memory
// reference model and an AXI slave with programmable per-channel delays.
module tb_mem_axi_bridge;

  localparam int AW  = 32;
  localparam int IDW = 4;

  logic           clk = 1'b0;
  logic           clrn = 1'b0;
  logic [AW-1:0]  s_a = '0;
  logic [31:0]    s_din = '0;
  logic [31:0]    s_dout;
  logic           s_strobe = 1'b0;
  logic           s_rw = 1'b0;
  logic [3:0]     s_wen = '0;
  logic [1:0]     s_size = '0;
  logic           s_ready;
  logic [IDW-1:0] arid;
  logic [AW-1:0]  araddr;
  logic [7:0]     arlen;
  logic [2:0]     arsize;
  logic [1:0]     arburst;
  logic           arvalid;
  logic           arready = 1'b0;
  logic [IDW-1:0] rid = '0;
  logic [31:0]    rdata = '0;
  logic [1:0]     rresp = '0;
  logic           rlast = 1'b0;
  logic           rvalid = 1'b0;
  logic           rready;
  logic [IDW-1:0] awid;
  logic [AW-1:0]  awaddr;
  logic [7:0]     awlen;
  logic [2:0]     awsize;
  logic [1:0]     awburst;
  logic           awvalid;
  logic           awready = 1'b0;
  logic [IDW-1:0] wid;
  logic [31:0]    wdata;
  logic [3:0]     wstrb;
  logic           wlast;
  logic           wvalid;
  logic           wready = 1'b0;
  logic [IDW-1:0] bid = '0;
  logic [1:0]     bresp = '0;
  logic           bvalid = 1'b0;
  logic           bready;

  mem_axi_bridge #(.A_WIDTH(AW), .ID_W(IDW), .TXN_ID(1)) dut (
    .clk(clk), .clrn(clrn),
    .s_a(s_a), .s_din(s_din), .s_dout(s_dout), .s_strobe(s_strobe), .s_rw(s_rw),
    .s_wen(s_wen), .s_size(s_size), .s_ready(s_ready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  logic [31:0] smem    [logic [31:0]];
  logic [31:0] mem_ref [logic [31:0]];
  logic [31:0] last_rd = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] smem_word(input logic [31:0] a);
    return smem.exists(a >> 2) ? smem[a >> 2] : 32'h0;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    return mem_ref.exists(a >> 2) ? mem_ref[a >> 2] : 32'h0;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic slave_idle();
    arready = 1'b0; awready = 1'b0; wready = 1'b0;
    rvalid = 1'b0; bvalid = 1'b0; rlast = 1'b0;
  endtask

  // One request from strobe to the idle cycle after s_ready. The slave raises each
  // ready after *_dly cycles of valid; rvalid/bvalid follow their address/data phases.
  task automatic txn(input logic rw, input logic [31:0] a, input logic [31:0] din,
                     input logic [3:0] wen, input logic [1:0] sz, input int ar_dly,
                     input int aw_dly, input int w_dly, input int r_dly, input int b_dly,
                     input logic [1:0] bresp_v);
    int ar_f, aw_f, w_f, r_f, b_f, sr_cnt, sr_it, ar_it, aw_it, w_it;
    int ar_seen, aw_seen, w_seen, exp_lat, last_it;
    logic pa, paw, pw;
    logic [31:0] cap_addr, cap_data, exp_dout;
    logic [3:0] cap_strb;
    ar_f = 0; aw_f = 0; w_f = 0; r_f = 0; b_f = 0; sr_cnt = 0; sr_it = 0;
    ar_it = 0; aw_it = 0; w_it = 0; ar_seen = 0; aw_seen = 0; w_seen = 0;
    pa = 1'b0; paw = 1'b0; pw = 1'b0;
    cap_addr = '0; cap_data = '0; cap_strb = '0;
    exp_lat = rw ? (((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly + 3) : (ar_dly + r_dly + 3);
    exp_dout = rw ? last_rd : ref_word(a);
    s_a = a; s_din = din; s_wen = wen; s_size = sz; s_rw = rw; s_strobe = 1'b1;
    for (int it = 1; it <= 60 && sr_cnt == 0; it++) begin
      @(negedge clk);
      if (it == 1)
        chk("valid_rise", 64'({arvalid, awvalid, wvalid}), rw ? 64'(3'b011) : 64'(3'b100));
      if (pa)  chk("arvalid_hold", 64'(arvalid), 64'(1));
      if (paw) chk("awvalid_hold", 64'(awvalid), 64'(1));
      if (pw)  chk("wvalid_hold", 64'(wvalid), 64'(1));
      arready = 1'b0; awready = 1'b0; wready = 1'b0;
      if (arvalid) begin
        chk("ar_fields", 64'({arid, arlen, arburst, arsize, araddr}),
            64'({4'd1, 8'd0, 2'b01, {1'b0, sz}, a}));
        arready = (ar_seen >= ar_dly);
        ar_seen++;
        if (arready) begin ar_f++; ar_it = it; end
      end
      if (awvalid) begin
        chk("aw_fields", 64'({awid, awlen, awburst, awsize, awaddr}),
            64'({4'd1, 8'd0, 2'b01, {1'b0, sz}, a}));
        awready = (aw_seen >= aw_dly);
        aw_seen++;
        if (awready) begin aw_f++; aw_it = it; cap_addr = awaddr; end
      end
      if (wvalid) begin
        chk("w_fields", 64'({wid, wlast, wstrb, wdata}), 64'({4'd1, 1'b1, wen, din}));
        wready = (w_seen >= w_dly);
        w_seen++;
        if (wready) begin w_f++; w_it = it; cap_data = wdata; cap_strb = wstrb; end
      end
      pa = arvalid && !arready;
      paw = awvalid && !awready;
      pw = wvalid && !wready;
      rvalid = 1'b0; rlast = 1'b0; rdata = $urandom; rresp = 2'($urandom); rid = 4'($urandom);
      if (ar_it > 0 && r_f == 0 && it >= ar_it + 1 + r_dly) begin
        rvalid = 1'b1; rlast = 1'b1; rdata = smem_word(araddr);
      end
      if (rvalid && rready) r_f++;
      last_it = (aw_it > w_it) ? aw_it : w_it;
      bvalid = 1'b0; bresp = bresp_v; bid = 4'($urandom);
      if (aw_it > 0 && w_it > 0 && b_f == 0 && it >= last_it + 1 + b_dly) bvalid = 1'b1;
      if (bvalid && bready) b_f++;
      if (s_ready) begin sr_cnt++; sr_it = it; s_strobe = 1'b0; end
    end
    chk("s_ready_seen", 64'(sr_cnt), 64'(1));
    chk("latency", 64'(sr_it), 64'(exp_lat));
    chk("s_dout", 64'(s_dout), 64'(exp_dout));
    chk("handshakes", 64'({8'(ar_f), 8'(r_f), 8'(aw_f), 8'(w_f), 8'(b_f)}),
        rw ? 64'(40'h00_00_01_01_01) : 64'(40'h01_01_00_00_00));
    @(negedge clk);
    slave_idle();
    chk("idle_after", 64'({s_ready, arvalid, awvalid, wvalid, rready, bready}), 64'(0));
    chk("s_dout_hold", 64'(s_dout), 64'(exp_dout));
    if (rw) begin
      if (aw_f > 0 && w_f > 0) smem[cap_addr >> 2] = merge(smem_word(cap_addr), cap_data, cap_strb);
      mem_ref[a >> 2] = merge(ref_word(a), din, wen);
    end else begin
      last_rd = exp_dout;
    end
  endtask

  initial begin
    logic rw_r;
    logic [1:0] sz_r;
    logic [31:0] a_r;
    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_ctl", 64'({s_ready, arvalid, awvalid, wvalid, rready, bready}), 64'(0));
    chk("reset_dout", 64'(s_dout), 64'(0));
    chk("reset_req", 64'({araddr, wdata}), 64'(0));
    clrn = 1'b1;
    @(negedge clk);

    smem[32'h1FC0_0010 >> 2]    = 32'hDEAD_BEEF;
    mem_ref[32'h1FC0_0010 >> 2] = 32'hDEAD_BEEF;

    txn(1'b0, 32'h1FC0_0010, 32'h0, 4'hF, 2'd2, 0, 0, 0, 0, 0, 2'b00);
    chk("first_read_data", 64'(s_dout), 64'(32'hDEAD_BEEF));
    txn(1'b1, 32'h8000_0004, 32'h1234_5678, 4'b0011, 2'd1, 0, 0, 2, 0, 1, 2'b00);
    txn(1'b1, 32'h8000_0008, 32'hCAFE_F00D, 4'b1111, 2'd2, 0, 2, 0, 0, 0, 2'b00);
    txn(1'b1, 32'h8000_000C, 32'hA5A5_5A5A, 4'b1100, 2'd1, 0, 1, 1, 0, 0, 2'b01);
    txn(1'b1, 32'h8000_0010, 32'h0BAD_CAFE, 4'b1111, 2'd2, 0, 0, 0, 0, 0, 2'b00);
    txn(1'b0, 32'h8000_0004, 32'h0, 4'h0, 2'd2, 5, 0, 0, 1, 0, 2'b00);
    chk("readback_half", 64'(s_dout), 64'(32'h0000_5678));
    txn(1'b1, 32'h8000_0014, 32'h7777_8888, 4'b0001, 2'd0, 0, 0, 0, 0, 0, 2'b10);
    txn(1'b0, 32'h8000_0014, 32'h0, 4'h0, 2'd0, 0, 0, 0, 0, 2, 2'b00);
    chk("readback_byte", 64'(s_dout), 64'(32'h0000_0088));

    // Abort a read while it waits in RDATA
    s_a = 32'h8000_0008; s_rw = 1'b0; s_size = 2'd2; s_strobe = 1'b1;
    @(negedge clk);
    chk("abort_arvalid", 64'(arvalid), 64'(1));
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    chk("abort_rready", 64'(rready), 64'(1));
    #2 clrn = 1'b0;
    #1 chk("abort_async", 64'({s_ready, arvalid, awvalid, wvalid, rready, bready}), 64'(0));
    chk("abort_dout", 64'(s_dout), 64'(0));
    last_rd = '0;
    s_strobe = 1'b0;
    @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
    chk("abort_quiet", 64'({s_ready, arvalid, awvalid, wvalid, rready, bready}), 64'(0));
    txn(1'b0, 32'h8000_0008, 32'h0, 4'h0, 2'd2, 0, 0, 0, 0, 0, 2'b00);
    chk("post_abort_read", 64'(s_dout), 64'(32'hCAFE_F00D));

    for (int n = 0; n < 40; n++) begin
      rw_r = 1'($urandom);
      sz_r = 2'($urandom_range(0, 2));
      a_r = 32'h8000_0000 | (32'($urandom_range(0, 7)) << 2);
      txn(rw_r, a_r, $urandom, 4'($urandom_range(1, 15)), sz_r,
          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 3), $urandom_range(0, 3), 2'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
